flt2fix_seq: RTL



---
 rtl/flt2fix_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/flt2fix_seq.sv
`timescale 1ns/1ps
// flt2fix_seq -- sequential float16 -> signed 8.8 fixed-point converter.
//
// Takes the float16 words produced by the fixed(8.8)->float16 stage and
// converts them back. Normalisation moves the magnitude one bit per cycle,
// rounding is round-half-to-even, and finite overflow either wraps (default)
// or saturates.
//
// Build option:
//   FLT2FIX_SAT_EN  defined   -> finite |x| >= 128 saturates to 0x7FFF/0x8000
//                   undefined -> finite |x| >= 128 shifts normally and wraps
//   In both builds ovf=1 for these operands, except exactly -128.0.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    request, sampled only in IDLE or DONE
//   flt_in   float16 operand {sign, exp[4:0], mant[9:0]}, latched on accept
//   fix_out  two's-complement 8.8 result, stable while done=1
//   done     result valid, held until the next accepted start
//   ovf      overflow or Inf/NaN operand, valid with done
//   busy     high in SHIFT, ROUND and NEG
module flt2fix_seq #(
   parameter int MAX_SHIFT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] flt_in,
   output logic [15:0] fix_out,
   output logic        done,
   output logic        ovf,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, SHIFT, ROUND, NEG, DONE} state_t;

   localparam logic [4:0] MAX_SH5 = 5'(MAX_SHIFT);

   state_t      state;
   logic [23:0] mag;        // 11-bit significand shifted left by up to 13
   logic        guard;
   logic        sticky;
   logic [3:0]  cnt;
   logic        sign_q;
   logic        dir_left;
   logic        ovf_pend;

   // ------------------------------------------------------------------
   // Operand decode, evaluated combinationally on the accepting cycle
   // ------------------------------------------------------------------
   logic [4:0]  exp_f;
   logic [4:0]  rdist;      // right-shift distance, 17 - exp
   logic        is_zero, is_inf, is_big, is_m128, go_left, big_ovf;
   logic [3:0]  k_in;
   logic        special;
   logic [15:0] spec_fix;
   logic        spec_ovf;

   assign exp_f = flt_in[14:10];
   assign rdist = 5'd17 - exp_f;

   always_comb begin
      is_zero  = (exp_f == 5'd0);
      is_inf   = (exp_f == 5'd31);
      is_big   = (exp_f >= 5'd22) && !is_inf;   // finite magnitude >= 128
      is_m128  = (flt_in == 16'hD800);          // -128.0 fits exactly
      go_left  = (exp_f >= 5'd17);
      big_ovf  = is_big && !is_m128;

      k_in = 4'd0;
      if (go_left)
         k_in = 4'(exp_f - 5'd17);
      else if (rdist >= MAX_SH5)
         k_in = 4'(MAX_SH5);                     // everything shifted out anyway
      else
         k_in = 4'(rdist);

      special  = 1'b0;
      spec_fix = 16'h0000;
      spec_ovf = 1'b0;
      if (is_zero) begin
         // zero and every subnormal round to 0
         special = 1'b1;
      end else if (is_inf) begin
         special  = 1'b1;
         spec_fix = flt_in[15] ? 16'h8000 : 16'h7FFF;
         spec_ovf = 1'b1;
      end
`ifdef FLT2FIX_SAT_EN
      else if (is_big) begin
         special  = 1'b1;
         spec_fix = flt_in[15] ? 16'h8000 : 16'h7FFF;
         spec_ovf = !is_m128;
      end
`else
      // wide operands take the ordinary left-shift path and wrap
`endif
   end

   // ------------------------------------------------------------------
   // Control and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         mag      <= '0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         dir_left <= 1'b0;
         ovf_pend <= 1'b0;
         fix_out  <= 16'h0000;
         done     <= 1'b0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sign_q   <= flt_in[15];
                  dir_left <= go_left;
                  mag      <= {13'b0, 1'b1, flt_in[9:0]};
                  guard    <= 1'b0;
                  sticky   <= 1'b0;
                  cnt      <= k_in;
                  ovf_pend <= big_ovf;
                  if (special) begin
                     // result is known now; skip the datapath entirely
                     state   <= DONE;
                     fix_out <= spec_fix;
                     ovf     <= spec_ovf;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state <= (k_in != 4'd0) ? SHIFT : ROUND;
                     done  <= 1'b0;
                     busy  <= 1'b1;
                  end
               end
            end

            SHIFT: begin
               if (dir_left) begin
                  mag <= mag << 1;
               end else begin
                  // sticky collects every bit that has already left guard
                  mag    <= mag >> 1;
                  guard  <= mag[0];
                  sticky <= sticky | guard;
               end
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= ROUND;
            end

            ROUND: begin
               // half-to-even; guard/sticky are zero on the left-shift path
               mag   <= mag + {23'b0, guard & (sticky | mag[0])};
               state <= NEG;
            end

            NEG: begin
               fix_out <= sign_q ? -mag[15:0] : mag[15:0];
               ovf     <= ovf_pend;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= DONE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
